// File: rtl/fridge_readout_pkg.sv
// fridge_pkg: shared word geometry, tag constants and readout state enum (FRIDGE_READOUT_PARITY_EN adds PAR)
package fridge_pkg;
  localparam int WORD_W = 5;
  localparam int TAG_W = 3;
  localparam int NUM_WORDS = 5;
  localparam logic [TAG_W-1:0] TAG_FGT = 3'd0;
  localparam logic [TAG_W-1:0] TAG_FRT = 3'd1;
  localparam logic [TAG_W-1:0] TAG_FGC = 3'd2;
  localparam logic [TAG_W-1:0] TAG_FRC = 3'd3;
  localparam logic [TAG_W-1:0] TAG_PWR = 3'd4;
  typedef enum logic [2:0] {
    IDLE,
    START,
    TAG,
    DATA,
`ifdef FRIDGE_READOUT_PARITY_EN
    PAR,
`endif
    STOP
  } state_e;
  function automatic logic [TAG_W-1:0] tag_of(input logic [2:0] w);
    return w == 3'd0 ? TAG_FGT : w == 3'd1 ? TAG_FRT : w == 3'd2 ? TAG_FGC : w == 3'd3 ? TAG_FRC : TAG_PWR;
  endfunction
endpackage

// File: rtl/fridge_readout_if.sv
// fridge_readout_if: request, settings and serial status signals of the readout port
interface fridge_readout_if;
  import fridge_pkg::*;
  logic req;
  logic [WORD_W-1:0] fgt, frt, fgc, frc;
  logic fgp, frp;
  logic tx, busy, done;
  modport master(output req, fgt, frt, fgc, frc, fgp, frp, input tx, busy, done);
  modport slave(input req, fgt, frt, fgc, frc, fgp, frp, output tx, busy, done);
endinterface

// File: rtl/fridge_bit_timer.sv
// fridge_bit_timer: bit_tick on the last cycle of each CLKS_PER_BIT bit period, held clear while disabled
module fridge_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_tick
);
  localparam int W = $clog2(CLKS_PER_BIT + 1);
  logic [W-1:0] cnt;
  assign bit_tick = en && cnt == W'(CLKS_PER_BIT - 1);
  // count cycles within the current bit, wrapping on each tick
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (!en || bit_tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/fridge_readout.sv
// fridge_readout: snapshots fridge settings on req and serialises them as five tagged words (FRIDGE_READOUT_PARITY_EN adds even parity)
module fridge_readout
  import fridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input logic clk,
  input logic rst,
  fridge_readout_if.slave bus
);
  state_e state, nxt_state;
  logic [2:0] word, nxt_word, bitn, nxt_bit;
  logic [WORD_W-1:0] s_fgt, s_frt, s_fgc, s_frc, nd;
  logic [TAG_W-1:0] nt;
  logic s_fgp, s_frp, tick, tx_nxt;
  fridge_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk(clk), .rst(rst), .en(state != IDLE), .bit_tick(tick)
  );
  // position of the bit that follows the current one, and the tx level it carries
  always_comb begin
    nxt_state = state;
    nxt_word = word;
    nxt_bit = bitn;
    case (state)
      START: begin
        nxt_state = TAG;
        nxt_bit = '0;
      end
      TAG: begin
        nxt_state = bitn == 3'(TAG_W - 1) ? DATA : TAG;
        nxt_bit = bitn == 3'(TAG_W - 1) ? 3'd0 : bitn + 3'd1;
      end
      DATA: begin
`ifdef FRIDGE_READOUT_PARITY_EN
        nxt_state = bitn == 3'(WORD_W - 1) ? PAR : DATA;
`else
        nxt_state = bitn == 3'(WORD_W - 1) ? STOP : DATA;
`endif
        nxt_bit = bitn == 3'(WORD_W - 1) ? 3'd0 : bitn + 3'd1;
      end
`ifdef FRIDGE_READOUT_PARITY_EN
      PAR: nxt_state = STOP;
`endif
      STOP: begin
        nxt_state = word == 3'(NUM_WORDS - 1) ? IDLE : START;
        nxt_word = word == 3'(NUM_WORDS - 1) ? word : word + 3'd1;
      end
      default: ;
    endcase
    nt = tag_of(nxt_word);
    nd = nxt_word == 3'd0 ? s_fgt : nxt_word == 3'd1 ? s_frt : nxt_word == 3'd2 ? s_fgc :
         nxt_word == 3'd3 ? s_frc : {3'b000, s_frp, s_fgp};
    tx_nxt = nxt_state == START ? 1'b0 :
             nxt_state == TAG ? nt[nxt_bit[1:0]] :
             nxt_state == DATA ? nd[nxt_bit] :
`ifdef FRIDGE_READOUT_PARITY_EN
             nxt_state == PAR ? ^{nt, nd} :
`endif
             1'b1;
  end
  // frame sequencer: accept and snapshot in IDLE, step one bit per tick, registered outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      word <= '0;
      bitn <= '0;
      {s_fgt, s_frt, s_fgc, s_frc, s_fgp, s_frp} <= '0;
      bus.tx <= 1'b1;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (state == IDLE) begin
        if (bus.req) begin
          {s_fgt, s_frt, s_fgc, s_frc, s_fgp, s_frp} <= {bus.fgt, bus.frt, bus.fgc, bus.frc, bus.fgp, bus.frp};
          word <= '0;
          bitn <= '0;
          state <= START;
          bus.tx <= 1'b0;
          bus.busy <= 1'b1;
        end
      end else if (tick) begin
        state <= nxt_state;
        word <= nxt_word;
        bitn <= nxt_bit;
        bus.tx <= tx_nxt;
        bus.busy <= nxt_state != IDLE;
        bus.done <= nxt_state == IDLE;
      end
    end
endmodule

// File: tb/tb_fridge_readout.sv
// tb_fridge_readout: randomized frames checked cycle by cycle against a bit-list model of the frame format
module tb_fridge_readout;
  localparam int CPB = 4;
`ifdef FRIDGE_READOUT_PARITY_EN
  localparam int W = 11;
`else
  localparam int W = 10;
`endif
  localparam int N = 5 * W * CPB;
  logic clk = 0, rst = 0;
  int checks = 0, errors = 0;
  bit exp_bits[$];
  fridge_readout_if bus();
  fridge_readout #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic void build(input logic [4:0] a, b, c, d, input logic p, q);
    logic [4:0] dv;
    logic [2:0] tg;
    exp_bits.delete();
    for (int w = 0; w < 5; w++) begin
      tg = 3'(w);
      dv = w == 0 ? a : w == 1 ? b : w == 2 ? c : w == 3 ? d : {3'b000, q, p};
      exp_bits.push_back(1'b0);
      for (int k = 0; k < 3; k++) exp_bits.push_back(tg[k]);
      for (int k = 0; k < 5; k++) exp_bits.push_back(dv[k]);
`ifdef FRIDGE_READOUT_PARITY_EN
      exp_bits.push_back(^{tg, dv});
`endif
      exp_bits.push_back(1'b1);
    end
  endfunction

  task automatic test_reset();
    bus.req = 0;
    {bus.fgt, bus.frt, bus.fgc, bus.frc, bus.fgp, bus.frp} = '0;
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.tx, bus.busy, bus.done} !== 3'b100) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: tx/busy/done=%b required 100", i, {bus.tx, bus.busy, bus.done});
      end
    end
  endtask

  // poke: cycle at which fgt changes to 9 and a stray req pulses; keep: hold req into the done cycle;
  // pre: request already accepted at the previous done cycle; cut: cycle at which rst is asserted
  task automatic frame(input string nm, input logic [4:0] a, b, c, d, input logic p, q,
                       input int poke, input bit keep, input bit pre, input int cut);
    int nb = 0;
    build(a, b, c, d, p, q);
    if (!pre) begin
      @(negedge clk);
      {bus.fgt, bus.frt, bus.fgc, bus.frc, bus.fgp, bus.frp} = {a, b, c, d, p, q};
      bus.req = 1;
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (i == 0) bus.req = 0;
      checks++;
      nb += bus.busy ? 1 : 0;
      if (bus.tx !== exp_bits[i / CPB] || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL %s cycle %0d bit %0d: tx=%b busy=%b done=%b required tx=%b busy=1 done=0",
                 nm, i, i / CPB, bus.tx, bus.busy, bus.done, exp_bits[i / CPB]);
      end
      if (i == cut) begin
        rst = 1;
        #1;
        checks++;
        if ({bus.tx, bus.busy, bus.done} !== 3'b100) begin
          errors++;
          $display("FAIL %s_async_reset: tx/busy/done=%b required 100", nm, {bus.tx, bus.busy, bus.done});
        end
        @(negedge clk);
        rst = 0;
        for (int j = 0; j < 2 * CPB; j++) begin
          @(negedge clk);
          checks++;
          if ({bus.tx, bus.busy, bus.done} !== 3'b100) begin
            errors++;
            $display("FAIL %s_after_reset: tx/busy/done=%b required 100", nm, {bus.tx, bus.busy, bus.done});
          end
        end
        return;
      end
      if (i == poke) begin
        bus.fgt = 5'd9;
        bus.req = 1;
      end
      if (i == poke + 1) bus.req = 0;
      if (i == N - 1 && keep) bus.req = 1;
    end
    checks++;
    if (nb != N) begin
      errors++;
      $display("FAIL %s_busy_len: busy cycles %0d required %0d", nm, nb, N);
    end
    @(negedge clk);
    checks++;
    if ({bus.tx, bus.busy, bus.done} !== 3'b101) begin
      errors++;
      $display("FAIL %s_done: tx/busy/done=%b required 101", nm, {bus.tx, bus.busy, bus.done});
    end
    if (!keep) begin
      @(negedge clk);
      checks++;
      if ({bus.tx, bus.busy, bus.done} !== 3'b100) begin
        errors++;
        $display("FAIL %s_after_done: tx/busy/done=%b required 100", nm, {bus.tx, bus.busy, bus.done});
      end
    end
  endtask

  task automatic test_full_frame();
    frame("full_frame", 5'd3, 5'd17, 5'd31, 5'd0, 1'b1, 1'b0, -10, 0, 0, -10);
  endtask

  task automatic test_snapshot_ignore();
    frame("snapshot", 5'd3, 5'd17, 5'd31, 5'd0, 1'b1, 1'b0, N / 3, 1, 0, -10);
    frame("back_to_back", 5'd9, 5'd17, 5'd31, 5'd0, 1'b1, 1'b0, -10, 0, 1, -10);
  endtask

  task automatic test_reset_mid_frame();
    frame("reset_mid", 5'd21, 5'd6, 5'd13, 5'd28, 1'b0, 1'b1, -10, 0, 0, (2 * W + 5) * CPB + 1);
    frame("after_reset", 5'd21, 5'd6, 5'd13, 5'd28, 1'b0, 1'b1, -10, 0, 0, -10);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++)
      frame("random", 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
            1'($urandom), 1'($urandom), -10, 0, 0, -10);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_snapshot_ignore();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fridge_readout.md
# fridge_readout

Serial status transmitter for the fridge controller: on request it snapshots the stored fridge/freezer temperature, capacity and power settings and sends them out as a fixed five-word serial frame. It is the read side of the settings store; the write side loads the registers and this block reads them back for a display or service port. It has one clock domain, and all operation after reset is synchronous.

## Interface
- CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range 1..255.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  start request; sampled only while busy=0.
- fgt  in  5  fridge temperature setting.
- frt  in  5  freezer temperature setting.
- fgc  in  5  fridge capacity setting.
- frc  in  5  freezer capacity setting.
- fgp  in  1  fridge power.
- frp  in  1  freezer power.
- tx  out  1  serial line; idles high.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse when a frame completes.

## Operation
- States: IDLE, START, TAG, DATA, PAR (only with the macro), STOP.
- In IDLE, a rising clk edge with req=1 does three things:
  - Snapshots all six inputs into internal registers.
  - Sets word index to 0.
  - Enters START.
- Input changes after the snapshot do not affect the frame in flight.
- Frame is five words sent back to back, with no idle bits between words.
- Word order and tags:
  - 0: tag 000, fgt.
  - 1: tag 001, frt.
  - 2: tag 010, fgc.
  - 3: tag 011, frc.
  - 4: tag 100, data {3'b000, frp, fgp}.
- Bits within a word, in order:
  - start bit 0;
  - tag bits, LSB first;
  - data bits, LSB first;
  - optional parity bit;
  - stop bit 1.
- After word 4's stop bit the block returns to IDLE.
- req while busy=1 is ignored and not queued.
- rst asserted at any time, including mid-frame, immediately forces:
  - tx=1, busy=0, done=0;
  - state IDLE;
  - word index, bit counter and tick counter to 0;
  - snapshot registers to 0.

## Timing
- Reset values: tx=1, busy=0, done=0.
- The edge that accepts req is edge 0. From the cycle after it:
  - busy=1;
  - tx=start bit.
- Each bit holds tx stable for exactly CLKS_PER_BIT cycles.
- Word length W is 10 bits, or 11 with parity.
- Frame length is 5·W·CLKS_PER_BIT cycles.
- The cycle after the last stop-bit cycle has busy=0, done=1 and tx=1.
- A req present in the done cycle is accepted. The next frame's start bit then follows in the next cycle, giving a minimum of one idle cycle between frames.
- CLKS_PER_BIT=1: one bit per cycle. There is no special-case behaviour.
- Tick counter wraps from CLKS_PER_BIT-1 to 0 on each bit advance. Its width is $clog2(CLKS_PER_BIT+1).

## Configuration
- FRIDGE_READOUT_PARITY_EN defined:
  - A PAR bit is inserted between the last data bit and the stop bit.
  - Its value is even parity over the 3 tag bits and 5 data bits (XOR of the eight bits).
  - W=11.
- Macro undefined:
  - No PAR state, W=10.
  - No parity logic is synthesised.

## Structure
- Shared package fridge_pkg holds:
  - WORD_W=5, TAG_W=3, NUM_WORDS=5;
  - tag constants TAG_FGT, TAG_FRT, TAG_FGC, TAG_FRC, TAG_PWR;
  - the readout state enum.
- Sub-module fridge_bit_timer, parameterised by CLKS_PER_BIT:
  - Takes clk, rst and an enable.
  - Outputs a one-cycle bit_tick at the end of each bit period.
  - Clears to 0 when disabled.
- The top level holds the FSM, the snapshot registers, the word/bit counters and the tx output mux.

## Test plan
- Reset idle: assert rst for 3 cycles, release, hold req=0 for 100 cycles -> tx=1, busy=0, done=0 throughout.
- Word 0 bit pattern: CLKS_PER_BIT=4, fgt=3, req pulse -> tx bit sequence 0,0,0,0,1,1,0,0,0,1, each bit held 4 cycles.
- Full frame:
  - Stimulus: fgt=3, frt=17, fgc=31, frc=0, fgp=1, frp=0.
  - Decoded words: (000,3), (001,17), (010,31), (011,0), (100,1).
  - busy high for exactly 200 cycles; done pulses once.
- Snapshot and ignore:
  - Stimulus: change fgt to 9 and pulse req mid-frame.
  - Required: the frame still carries fgt=3; no second frame starts.
  - Stimulus: req held in the done cycle. Required: a new frame starts with fgt=9.
- Reset mid-frame: assert rst during word 2 DATA -> tx=1 and busy=0 within the same cycle, with no done pulse. A subsequent req sends a complete, correct frame.
- Parity (FRIDGE_READOUT_PARITY_EN):
  - frt=17 with tag 001 -> parity bit 1.
  - fgc=31 with tag 010 -> parity bit 0.
  - busy high for 220 cycles at CLKS_PER_BIT=4.
